prbs_checker: RTL

//  Receive-side PRBS checker for the bit error tester. Takes the synchronised rx bit

---
 rtl/prbs_checker.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS receive checker: seeds a local LFSR from the rx stream,
// verifies alignment, then counts mismatches and drops lock on windowed error bursts.
module prbs_checker #(
    parameter int unsigned ORDER          = 14,
    parameter int unsigned LOCK_COUNT     = 32,
    parameter int unsigned WINDOW         = 64,
    parameter int unsigned LOSS_THRESHOLD = 8,
    parameter int unsigned ERR_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 data_in,
    output logic                 locked,
    output logic                 error_pulse,
    output logic [ERR_WIDTH-1:0] error_count,
    output logic                 count_saturated
);

    localparam logic [1:0] ST_SEED   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int unsigned FILL_W  = $clog2(ORDER);
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT);
    localparam int unsigned WIN_W   = $clog2(WINDOW);
    localparam int unsigned WERR_W  = $clog2(LOSS_THRESHOLD + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(ORDER - 1);
    localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0]  LOSS_THR  = WERR_W'(LOSS_THRESHOLD);

    // Bit k-1 of the mask marks tap x^k, i.e. the bit received k cycles ago.
    function automatic logic [19:0] tap_mask(input int unsigned n);
        logic [19:0] m;
        m = '0;
        case (n)
            10: begin m[9] = 1'b1; m[6] = 1'b1; end
            11: begin m[10] = 1'b1; m[8] = 1'b1; end
            12: begin m[11] = 1'b1; m[10] = 1'b1; m[9] = 1'b1; m[3] = 1'b1; end
            13: begin m[12] = 1'b1; m[11] = 1'b1; m[10] = 1'b1; m[7] = 1'b1; end
            14: begin m[13] = 1'b1; m[12] = 1'b1; m[11] = 1'b1; m[1] = 1'b1; end
            15: begin m[14] = 1'b1; m[13] = 1'b1; end
            16: begin m[15] = 1'b1; m[14] = 1'b1; m[12] = 1'b1; m[3] = 1'b1; end
            17: begin m[16] = 1'b1; m[13] = 1'b1; end
            18: begin m[17] = 1'b1; m[10] = 1'b1; end
            19: begin m[18] = 1'b1; m[17] = 1'b1; m[16] = 1'b1; m[13] = 1'b1; end
            20: begin m[19] = 1'b1; m[16] = 1'b1; end
            default: m = '0;
        endcase
        return m;
    endfunction

    localparam logic [19:0]      TAP_ALL = tap_mask(ORDER);
    localparam logic [ORDER-1:0] TAPS    = TAP_ALL[ORDER-1:0];

    logic [1:0]           state;
    logic [ORDER-1:0]     lfsr;
    logic [FILL_W-1:0]    fill_cnt;
    logic [MATCH_W-1:0]   match_cnt;
    logic [WIN_W-1:0]     win_cnt;
    logic [WERR_W-1:0]    win_err;
    logic                 predicted;
    logic                 mismatch;
    logic [WERR_W-1:0]    win_err_next;
    logic                 loss;
    logic                 count_err;
    logic [ERR_WIDTH-1:0] count_next;

    always_comb begin
        predicted    = ^(lfsr & TAPS);
        mismatch     = data_in ^ predicted;
        win_err_next = win_err + WERR_W'(mismatch);
        loss         = (win_err_next >= LOSS_THR);
        count_err    = enable && (state == ST_LOCKED) && mismatch;
        count_next   = error_count + ERR_WIDTH'(1);
    end

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_SEED;
            lfsr        <= '0;
            fill_cnt    <= '0;
            match_cnt   <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            error_pulse <= 1'b0;
        end else if (!enable) begin
            error_pulse <= 1'b0;
        end else begin
            error_pulse <= 1'b0;
            case (state)
                ST_SEED: begin
                    lfsr <= {lfsr[ORDER-2:0], data_in};
                    if (fill_cnt == FILL_LAST) begin
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                        state     <= ST_VERIFY;
                    end else begin
                        fill_cnt <= fill_cnt + FILL_W'(1);
                    end
                end
                ST_VERIFY: begin
                    lfsr <= {lfsr[ORDER-2:0], data_in};
                    // An all-zero register predicts zeros forever, so it must never earn lock.
                    if ((lfsr == '0) || mismatch) begin
                        match_cnt <= '0;
                    end else if (match_cnt == LOCK_LAST) begin
                        match_cnt <= '0;
                        win_cnt   <= '0;
                        win_err   <= '0;
                        state     <= ST_LOCKED;
                    end else begin
                        match_cnt <= match_cnt + MATCH_W'(1);
                    end
                end
                ST_LOCKED: begin
                    lfsr        <= {lfsr[ORDER-2:0], predicted};
                    error_pulse <= mismatch;
                    if (loss) begin
                        fill_cnt <= '0;
                        state    <= ST_SEED;
                    end else if (win_cnt == WIN_LAST) begin
                        win_cnt <= '0;
                        win_err <= '0;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                        win_err <= win_err_next;
                    end
                end
                default: state <= ST_SEED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_count     <= '0;
            count_saturated <= 1'b0;
        end else if (clear) begin
            error_count     <= '0;
            count_saturated <= 1'b0;
        end else if (count_err && !(&error_count)) begin
            error_count <= count_next;
            if (&count_next) count_saturated <= 1'b1;
        end
    end

endmodule
